// File: rtl/register_pkg.sv
// Shared defaults for the generic enabled/clearable storage register.
package register_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 32;
  localparam int unsigned DEFAULT_RESET_VAL = 0;

endpackage

// File: rtl/register.sv
// Generic D-type register with load enable and synchronous clear.
// Reset is asynchronous and active-high, despite the port name rst_l.
module register
  import register_pkg::*;
#(
  parameter WIDTH     = DEFAULT_WIDTH,
  parameter RESET_VAL = DEFAULT_RESET_VAL
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  // Remembers that reset has been applied; only the X check below reads it.
  logic seen_rst;

  // Reset wins over clear, and clear wins over load.
  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      Q        <= RST_Q;
      seen_rst <= 1'b1;
    end else if (clear) begin
      Q <= RST_Q;
    end else if (en) begin
      Q <= D;
    end
  end

  // Simulation-only sanity checks.
  always @(posedge clk) begin
    assert (WIDTH >= 1);
    if (seen_rst && !rst_l) assert (!$isunknown(Q));
  end

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: directed vectors plus random traffic
// across several widths, compared every cycle against a behavioural model.
module tb_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] d = '0;

  logic [7:0]  q8;
  logic        q1a;
  logic        q1b;
  logic [14:0] q15;
  logic [31:0] q32;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  localparam int N = 5;
  logic [31:0] rv   [N] = '{32'hA5, 32'h1, 32'h0, 32'h2B3C, 32'hDEADBEEF};
  logic [31:0] mask [N] = '{32'hFF, 32'h1, 32'h1, 32'h7FFF, 32'hFFFF_FFFF};
  logic [31:0] mdl  [N];

  always #5 clk = ~clk;

  register #(8, 8'hA5) u_r8 (
    .clk(clk), .rst_l(rst), .en(en), .clear(clear), .D(d[7:0]), .Q(q8));
  register #(1, 1'b1) u_r1a (
    .clk(clk), .rst_l(rst), .en(en), .clear(clear), .D(d[0]), .Q(q1a));
  register #(1, 1'b0) u_r1b (
    .clk(clk), .rst_l(rst), .en(en), .clear(clear), .D(d[0]), .Q(q1b));
  register #(15, 15'h2B3C) u_r15 (
    .clk(clk), .rst_l(rst), .en(en), .clear(clear), .D(d[14:0]), .Q(q15));
  register #(32, 32'hDEADBEEF) u_r32 (
    .clk(clk), .rst_l(rst), .en(en), .clear(clear), .D(d), .Q(q32));

  // Model: reset forces the reset value, otherwise clear > load > hold.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      if (rst || clear) mdl[i] = rv[i];
      else if (en)      mdl[i] = d & mask[i];
    end
  end

  function automatic logic [31:0] actual(input int i);
    case (i)
      0:       return {24'b0, q8};
      1:       return {31'b0, q1a};
      2:       return {31'b0, q1b};
      3:       return {17'b0, q15};
      default: return q32;
    endcase
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (actual(i) !== mdl[i]) begin
          errors++;
          $display("FAIL model[%0d] t=%0t got=%h want=%h", i, $time, actual(i), mdl[i]);
        end
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic [31:0] dv);
    en = e; clear = c; d = dv;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h3C);
    tick();
    // Reset pulse between edges: value appears without any clock.
    rst = 1'b1;
    #1;
    lit("rst_async_r8", {24'b0, q8}, 32'hA5);
    lit("rst_async_r1a", {31'b0, q1a}, 32'h1);
    lit("rst_async_r1b", {31'b0, q1b}, 32'h0);
    lit("rst_async_r15", {17'b0, q15}, 32'h2B3C);
    lit("rst_async_r32", q32, 32'hDEADBEEF);
    #1 rst = 1'b0;
    #1;
    lit("rst_release_hold", {24'b0, q8}, 32'hA5);
    chk_en = 1'b1;

    // Load, then hold for three edges with en low.
    tick();
    lit("load_r8", {24'b0, q8}, 32'h3C);
    lit("recent_rst_first", {31'b0, q1a}, 32'h0);
    tick();
    tick();
    lit("recent_rst_stays", {31'b0, q1a}, 32'h0);
    drive(1'b0, 1'b0, 32'hFF);
    repeat (3) tick();
    lit("hold_r8", {24'b0, q8}, 32'h3C);

    // Clear beats load, then load resumes.
    drive(1'b1, 1'b1, 32'h77);
    tick();
    lit("clear_prio_r8", {24'b0, q8}, 32'hA5);
    lit("clear_prio_r32", q32, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 32'h77);
    tick();
    lit("after_clear_r8", {24'b0, q8}, 32'h77);

    // Flush-style 1-bit usage.
    drive(1'b1, 1'b0, 32'h1);
    tick();
    lit("flush_load", {31'b0, q1b}, 32'h1);
    drive(1'b1, 1'b1, 32'h1);
    tick();
    lit("flush_clear", {31'b0, q1b}, 32'h0);

    // Random traffic with occasional reset cycles.
    for (int n = 0; n < 1000; n++) begin
      rst = ($urandom_range(39) == 0);
      drive(1'($urandom_range(1)), ($urandom_range(3) == 0), $urandom);
      tick();
    end
    rst = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
